// File: rtl/gray_pkg.sv
// Shared gray-code helpers and the receive-side FSM state type.
// Functions work on a fixed wide word; callers zero-extend narrower values.
package gray_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } gsync_state_t;

    function automatic logic [MAX_W-1:0] b2g(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Binary bit i is the XOR of all gray bits at or above i.
    function automatic logic [MAX_W-1:0] g2b(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

    function automatic logic multi_bit(input logic [MAX_W-1:0] d);
        return (d & (d - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/gray_sync_rx_if.sv
// Bus bundle between the gray receiver and its user: gray input, error clear,
// and the registered binary/delta/error results.
interface gray_sync_rx_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     gray_i;
    logic                 clr_err_i;
    logic [WIDTH-1:0]     bin_o;
    logic [WIDTH-1:0]     delta_o;
    logic                 chg_o;
    logic                 err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    modport master (
        output gray_i, clr_err_i,
        input  bin_o, delta_o, chg_o, err_o, err_cnt_o
    );

    modport slave (
        input  gray_i, clr_err_i,
        output bin_o, delta_o, chg_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end
endmodule

// File: rtl/gray_sync_rx.sv
// Receive side of a gray-coded count crossing: synchronizes gray_i, converts to
// binary, reports per-change deltas and flags illegal multi-bit transitions.
module gray_sync_rx
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    gray_sync_rx_if.slave   bus
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     sync_r [SYNC_STAGES];
    logic [WIDTH-1:0]     prev_gray_r;
    logic [WIDTH-1:0]     bin_r;
    logic [WIDTH-1:0]     delta_r;
    logic                 chg_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0]     fill_cnt_r;
    logic [CNT_W-1:0]     fill_cnt_nxt_s;
    gsync_state_t         state_r;
    gsync_state_t         state_nxt_s;

    logic [WIDTH-1:0]     samp_s;
    logic [WIDTH-1:0]     bin_s;
    logic [WIDTH-1:0]     diff_s;
    logic                 step_s;
    logic                 err_hit_s;

    assign samp_s    = sync_r[SYNC_STAGES-1];
    assign diff_s    = samp_s ^ prev_gray_r;
    assign step_s    = (state_r == RUN) && (diff_s != {WIDTH{1'b0}});
    assign err_hit_s = (state_r == RUN) && multi_bit(MAX_W'(diff_s));

    gray2bin #(.WIDTH(WIDTH)) u_g2b (
        .gray (samp_s),
        .bin  (bin_s)
    );

    // Plain flop chain: no logic between stages so each bit resolves independently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= bus.gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // FSM state and fill-counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= FILL;
            fill_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            fill_cnt_r <= fill_cnt_nxt_s;
        end
    end

    // Next state: FILL waits until the chain holds real samples, PRIME seeds history.
    always_comb begin
        state_nxt_s    = state_r;
        fill_cnt_nxt_s = fill_cnt_r;
        case (state_r)
            FILL: begin
                if (fill_cnt_r == CNT_W'(SYNC_STAGES - 1)) begin
                    state_nxt_s    = PRIME;
                    fill_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    fill_cnt_nxt_s = fill_cnt_r + CNT_W'(1);
                end
            end
            PRIME:   state_nxt_s = RUN;
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = FILL;
        endcase
    end

    // Output registers: PRIME seeds bin/prev without a delta, RUN tracks changes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_gray_r <= {WIDTH{1'b0}};
            bin_r       <= {WIDTH{1'b0}};
            delta_r     <= {WIDTH{1'b0}};
            chg_r       <= 1'b0;
        end else begin
            chg_r <= step_s;
            if (state_r == PRIME) begin
                prev_gray_r <= samp_s;
                bin_r       <= bin_s;
            end else if (step_s) begin
                prev_gray_r <= samp_s;
                bin_r       <= bin_s;
                delta_r     <= bin_s - bin_r;
            end else begin
                prev_gray_r <= prev_gray_r;
                bin_r       <= bin_r;
                delta_r     <= delta_r;
            end
        end
    end

    // Sticky error and saturating counter; a new error beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (err_hit_s) begin
            err_r <= 1'b1;
            if (err_cnt_r != {ERR_CNT_W{1'b1}}) begin
                err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else if (bus.clr_err_i) begin
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else begin
            err_r     <= err_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.bin_o     = bin_r;
    assign bus.delta_o   = delta_r;
    assign bus.chg_o     = chg_r;
    assign bus.err_o     = err_r;
    assign bus.err_cnt_o = err_cnt_r;

endmodule
